// File: rtl/if_fetch_if.sv
// Fetch-side bundle: instruction memory req/ack, ID-stage valid/ready, redirect.
// Latency: none (wires only).
// Backpressure: mem side via mem_ack, ID side via id_ready.
interface if_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        inst_addr_err;

    // Fetch unit side.
    modport master (
        output mem_req, mem_addr, inst_code, inst_pc, inst_valid, inst_addr_err,
        input  mem_ack, mem_rdata, id_ready, redirect, redirect_target
    );

    // Memory / decode / branch-resolution side.
    modport slave (
        input  mem_req, mem_addr, inst_code, inst_pc, inst_valid, inst_addr_err,
        output mem_ack, mem_rdata, id_ready, redirect, redirect_target
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: holds pc, reads imem over req/ack, hands words to ID with delay-slot redirects.
// Latency: 1 cycle after mem_ack to inst_valid; at best one instruction per 2 cycles plus memory latency.
// Backpressure: holds the word until id_ready; no new request while held. Optional IF_ALIGN_CHECK_EN flags misaligned pc.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] NOP_CODE = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    if_fetch_if.master bus
);
    typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic        redir_pend;
    logic        mem_req;
    logic        inst_valid;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic        inst_addr_err;

    logic [31:0] tgt;
    logic [31:0] pc_inc;
    logic [31:0] pc_load;
    logic        req_ok;
    logic        misaligned;

    // Next-pc candidates and alignment qualifiers.
    always_comb begin
`ifdef IF_ALIGN_CHECK_EN
        tgt        = bus.redirect_target;
`else
        tgt        = bus.redirect_target & ~32'h3;
`endif
        pc_inc     = pc + 32'd4;
        // pc that will be used for the next request when leaving BOOT/HOLD
        pc_load    = bus.redirect ? tgt : pc;
`ifdef IF_ALIGN_CHECK_EN
        req_ok     = (pc_load[1:0] == 2'b00);
        misaligned = (pc[1:0] != 2'b00);
`else
        req_ok     = 1'b1;
        misaligned = 1'b0;
`endif
    end

    // Fetch FSM with registered request and ID-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_BOOT;
            pc            <= RESET_PC;
            redir_pc      <= 32'h0;
            redir_pend    <= 1'b0;
            mem_req       <= 1'b0;
            inst_valid    <= 1'b0;
            inst_code     <= NOP_CODE;
            inst_pc       <= 32'h0;
            inst_addr_err <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    pc      <= pc_load;
                    mem_req <= req_ok;
                    state   <= S_REQ;
                end
                S_REQ: begin
                    if (misaligned) begin
                        // No request was issued; report the bad address as a held entry.
                        // redir_pend cannot be set here since it only arms on aligned requests.
                        state         <= S_HOLD;
                        inst_valid    <= 1'b1;
                        inst_code     <= NOP_CODE;
                        inst_pc       <= pc;
                        inst_addr_err <= 1'b1;
                        pc            <= pc_load;
                    end else if (bus.mem_ack) begin
                        state      <= S_HOLD;
                        mem_req    <= 1'b0;
                        inst_valid <= 1'b1;
                        inst_code  <= bus.mem_rdata;
                        inst_pc    <= pc;
                        // Same-cycle redirect is newer than any pending one.
                        if (bus.redirect)
                            pc <= tgt;
                        else if (redir_pend)
                            pc <= redir_pc;
                        else
                            pc <= pc_inc;
                        redir_pend <= 1'b0;
                    end else if (bus.redirect) begin
                        // In-flight word is the delay slot; remember the target, last one wins.
                        redir_pend <= 1'b1;
                        redir_pc   <= tgt;
                    end
                end
                S_HOLD: begin
                    pc <= pc_load;
                    if (bus.id_ready) begin
                        state         <= S_REQ;
                        mem_req       <= req_ok;
                        inst_valid    <= 1'b0;
                        inst_code     <= NOP_CODE;
                        inst_addr_err <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_BOOT;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req       = mem_req;
    assign bus.mem_addr      = pc;
    assign bus.inst_valid    = inst_valid;
    assign bus.inst_code     = inst_code;
    assign bus.inst_pc       = inst_pc;
    assign bus.inst_addr_err = inst_addr_err;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: sequencing, stalls, delay-slot redirects, wrap, alignment, reset.
// Latency: memory model acks a configurable number of cycles after mem_req.
// Backpressure: id_ready driven per scenario.
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    if_fetch_if bus();

    if_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_idle();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.id_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'h0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns at the first negedge where mem_req is high.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Ack lat cycles after the request was observed (lat >= 1).
    task automatic mem_ack_after(input int lat, input logic [31:0] data);
        repeat (lat - 1) @(negedge clk);
        bus.mem_rdata = data;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    task automatic consume();
        bus.id_ready = 1'b1;
        @(negedge clk);
        bus.id_ready = 1'b0;
    endtask

    task automatic fetch_quiet(input logic [31:0] data);
        bit ok;
        wait_req(ok);
        if (!ok) begin
            $display("FAIL fetch_quiet: mem_req timeout");
            $fatal(1);
        end
        mem_ack_after(1, data);
        consume();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        checks += 6;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
        if (bus.inst_code !== 32'h0) begin errors++; $display("FAIL reset_inst_code: got %h want 00000000", bus.inst_code); end
        if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 00000000", bus.inst_pc); end
        if (bus.inst_addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b want 0", bus.inst_addr_err); end
        if (bus.mem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_mem_addr: got %h want bfc00000", bus.mem_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] addr;
        logic [31:0] data;
        for (int i = 0; i < 3; i++) begin
            addr = 32'hBFC0_0000 + 32'(4 * i);
            data = 32'h1000_0000 + 32'(i);
            wait_req(ok);
            checks += 2;
            if (!ok) begin errors++; $display("FAIL seq_req_timeout: fetch %0d got no mem_req", i); end
            if (bus.mem_addr !== addr) begin errors++; $display("FAIL seq_mem_addr: got %h want %h", bus.mem_addr, addr); end
            mem_ack_after(1, data);
            checks += 4;
            if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b want 1", bus.inst_valid); end
            if (bus.inst_code !== data) begin errors++; $display("FAIL seq_inst_code: got %h want %h", bus.inst_code, data); end
            if (bus.inst_pc !== addr) begin errors++; $display("FAIL seq_inst_pc: got %h want %h", bus.inst_pc, addr); end
            if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL seq_req_in_hold: got %b want 0", bus.mem_req); end
            consume();
            checks++;
            if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL seq_consumed: got %b want 0", bus.inst_valid); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        wait_req(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL stall_req_timeout: no mem_req"); end
        if (bus.mem_addr !== 32'hBFC0_000C) begin errors++; $display("FAIL stall_mem_addr: got %h want bfc0000c", bus.mem_addr); end
        mem_ack_after(1, 32'hCAFE_0003);
        for (int k = 0; k < 5; k++) begin
            checks += 4;
            if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", k, bus.inst_valid); end
            if (bus.inst_code !== 32'hCAFE_0003) begin errors++; $display("FAIL stall_code[%0d]: got %h want cafe0003", k, bus.inst_code); end
            if (bus.inst_pc !== 32'hBFC0_000C) begin errors++; $display("FAIL stall_pc[%0d]: got %h want bfc0000c", k, bus.inst_pc); end
            if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b want 0", k, bus.mem_req); end
            // stray ack while holding must be ignored
            bus.mem_ack = (k == 1);
            bus.mem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        consume();
        wait_req(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL stall_next_timeout: no mem_req"); end
        if (bus.mem_addr !== 32'hBFC0_0010) begin errors++; $display("FAIL stall_next_addr: got %h want bfc00010", bus.mem_addr); end
    endtask

    task automatic test_redirect_req();
        bit ok;
        do_reset();
        fetch_quiet(32'h2222_0000);
        fetch_quiet(32'h2222_0004);
        wait_req(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL rreq_timeout: no mem_req"); end
        if (bus.mem_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL rreq_addr: got %h want bfc00008", bus.mem_addr); end
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h8000_0100;
        @(negedge clk);
        bus.redirect = 1'b0;
        checks += 2;
        if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rreq_req_held: got %b want 1", bus.mem_req); end
        if (bus.mem_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL rreq_addr_held: got %h want bfc00008", bus.mem_addr); end
        @(negedge clk);
        mem_ack_after(1, 32'h2222_0008);
        checks += 2;
        if (bus.inst_code !== 32'h2222_0008) begin errors++; $display("FAIL rreq_slot_code: got %h want 22220008", bus.inst_code); end
        if (bus.inst_pc !== 32'hBFC0_0008) begin errors++; $display("FAIL rreq_slot_pc: got %h want bfc00008", bus.inst_pc); end
        consume();
        wait_req(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL rreq_next_timeout: no mem_req"); end
        if (bus.mem_addr !== 32'h8000_0100) begin errors++; $display("FAIL rreq_target: got %h want 80000100", bus.mem_addr); end
    endtask

    task automatic test_redirect_hold();
        bit ok;
        mem_ack_after(1, 32'h3333_0100);
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h8000_0200;
        bus.id_ready = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.id_ready = 1'b0;
        checks += 2;
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rhold_consumed: got %b want 0", bus.inst_valid); end
        if (bus.inst_code !== 32'h0) begin errors++; $display("FAIL rhold_nop: got %h want 00000000", bus.inst_code); end
        wait_req(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL rhold_timeout: no mem_req"); end
        if (bus.mem_addr !== 32'h8000_0200) begin errors++; $display("FAIL rhold_target: got %h want 80000200", bus.mem_addr); end
    endtask

    task automatic test_double_redirect();
        bit ok;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'hA000_0000;
        @(negedge clk);
        bus.redirect_target = 32'hA000_0040;
        @(negedge clk);
        bus.redirect = 1'b0;
        @(negedge clk);
        mem_ack_after(1, 32'h4444_0200);
        checks++;
        if (bus.inst_pc !== 32'h8000_0200) begin errors++; $display("FAIL dbl_slot_pc: got %h want 80000200", bus.inst_pc); end
        consume();
        wait_req(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL dbl_timeout: no mem_req"); end
        if (bus.mem_addr !== 32'hA000_0040) begin errors++; $display("FAIL dbl_last_wins: got %h want a0000040", bus.mem_addr); end
    endtask

    task automatic test_wrap();
        bit ok;
        mem_ack_after(1, 32'h5555_0040);
        bus.redirect = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        bus.id_ready = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.id_ready = 1'b0;
        wait_req(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL wrap_timeout1: no mem_req"); end
        if (bus.mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h want fffffffc", bus.mem_addr); end
        mem_ack_after(1, 32'h5555_FFFC);
        checks++;
        if (bus.inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst_pc: got %h want fffffffc", bus.inst_pc); end
        consume();
        wait_req(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL wrap_timeout2: no mem_req"); end
        if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 00000000", bus.mem_addr); end
    endtask

    task automatic test_misaligned();
        bit ok;
        mem_ack_after(1, 32'h6666_0000);
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h8000_0102;
        bus.id_ready = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.id_ready = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b want 0", bus.mem_req); end
        @(negedge clk);
        checks += 5;
        if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL mis_valid: got %b want 1", bus.inst_valid); end
        if (bus.inst_addr_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", bus.inst_addr_err); end
        if (bus.inst_code !== 32'h0) begin errors++; $display("FAIL mis_code: got %h want 00000000", bus.inst_code); end
        if (bus.inst_pc !== 32'h8000_0102) begin errors++; $display("FAIL mis_pc: got %h want 80000102", bus.inst_pc); end
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_req_hold: got %b want 0", bus.mem_req); end
        consume();
        checks += 2;
        if (bus.inst_addr_err !== 1'b0) begin errors++; $display("FAIL mis_err_clear: got %b want 0", bus.inst_addr_err); end
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_reenter_req: got %b want 0", bus.mem_req); end
        @(negedge clk);
        checks++;
        if (bus.inst_addr_err !== 1'b1) begin errors++; $display("FAIL mis_reenter_err: got %b want 1", bus.inst_addr_err); end
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h8000_0300;
        bus.id_ready = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.id_ready = 1'b0;
        wait_req(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL mis_recover_timeout: no mem_req"); end
        if (bus.mem_addr !== 32'h8000_0300) begin errors++; $display("FAIL mis_recover_addr: got %h want 80000300", bus.mem_addr); end
        if (bus.inst_addr_err !== 1'b0) begin errors++; $display("FAIL mis_recover_err: got %b want 0", bus.inst_addr_err); end
`else
        wait_req(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL mis_timeout: no mem_req"); end
        if (bus.mem_addr !== 32'h8000_0100) begin errors++; $display("FAIL mis_forced_align: got %h want 80000100", bus.mem_addr); end
        if (bus.inst_addr_err !== 1'b0) begin errors++; $display("FAIL mis_err_tied: got %b want 0", bus.inst_addr_err); end
`endif
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", bus.mem_req); end
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus.inst_valid); end
        if (bus.mem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rmid_pc: got %h want bfc00000", bus.mem_addr); end
        @(negedge clk);
        // ack arriving while still in boot must not be captured
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks += 3;
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale_ack: got %b want 0", bus.inst_valid); end
        if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rmid_restart_req: got %b want 1", bus.mem_req); end
        if (bus.mem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rmid_restart_addr: got %h want bfc00000", bus.mem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_req();
        test_redirect_hold();
        test_double_redirect();
        test_wrap();
        test_misaligned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
